// File: rtl/fb_arbiter_if.sv
// Bus bundle between the framebuffer arbiter, its VGA and CPU requesters,
// the single-port framebuffer memory and the buffer-swap control.
interface fb_arbiter_if #(
  parameter int ADDR_W = 17
);
  logic              vga_rd;
  logic [39:0]       vga_addr;
  logic [79:0]       vga_data;
  logic              cpu_req;
  logic              cpu_we;
  logic [39:0]       cpu_addr;
  logic [79:0]       cpu_wdata;
  logic [79:0]       cpu_rdata;
  logic              cpu_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [79:0]       mem_wdata;
  logic [79:0]       mem_rdata;
  logic              swap_req;
  logic              frame_end;
  logic              fb_select;
  logic              swap_pending;

  modport slave (
    input  vga_rd, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           mem_rdata, swap_req, frame_end,
    output vga_data, cpu_rdata, cpu_ack, mem_en, mem_we, mem_addr,
           mem_wdata, fb_select, swap_pending
  );

  modport master (
    output vga_rd, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           mem_rdata, swap_req, frame_end,
    input  vga_data, cpu_rdata, cpu_ack, mem_en, mem_we, mem_addr,
           mem_wdata, fb_select, swap_pending
  );
endinterface

// File: rtl/fb_arbiter.sv
// Framebuffer memory arbiter: VGA reads take strict priority over a 3-state
// CPU access FSM on one memory port; also tracks double-buffer swap requests.
module fb_arbiter #(
  parameter int ADDR_W = 17
) (
  input logic         clk,
  input logic         rst,
  fb_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              cpu_issue_s;
  logic              mem_en_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic              cpu_ack_q;
  logic [79:0]       cpu_rdata_q;
  logic              vga_pend_q;
  logic [79:0]       vga_hold_q;
  logic              fb_select_q;
  logic              fb_select_d;
  logic              swap_pending_q;
  logic              swap_pending_d;
  logic              unused_addr_s;

  // Upper address bits beyond the memory word address carry no meaning here.
  assign unused_addr_s = ^{bus.vga_addr[39:ADDR_W], bus.cpu_addr[39:ADDR_W]};

  // Port issue decision: VGA wins every cycle; CPU only issues from IDLE.
  always_comb begin
    cpu_issue_s = 1'b0;
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = bus.cpu_addr[ADDR_W-1:0];
    if (rst) begin
      mem_en_s = 1'b0;
    end else if (bus.vga_rd) begin
      mem_en_s   = 1'b1;
      mem_addr_s = bus.vga_addr[ADDR_W-1:0];
    end else if ((state_q == ST_IDLE) && bus.cpu_req) begin
      cpu_issue_s = 1'b1;
      mem_en_s    = 1'b1;
      mem_we_s    = bus.cpu_we;
    end else begin
      cpu_issue_s = 1'b0;
    end
  end

  // CPU access sequencing: writes ack next cycle, reads pass through RD first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_issue_s) begin
          state_d = bus.cpu_we ? ST_ACK : ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD:   state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A swap arriving together with frame_end takes effect at once; repeats while pending are dropped.
  always_comb begin
    fb_select_d    = fb_select_q;
    swap_pending_d = swap_pending_q;
    if (bus.frame_end && (swap_pending_q || bus.swap_req)) begin
      fb_select_d    = ~fb_select_q;
      swap_pending_d = 1'b0;
    end else if (bus.swap_req) begin
      swap_pending_d = 1'b1;
    end else begin
      swap_pending_d = swap_pending_q;
    end
  end

  // State, CPU return data, VGA return tracking and buffer-select registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cpu_ack_q      <= 1'b0;
      cpu_rdata_q    <= 80'd0;
      vga_pend_q     <= 1'b0;
      vga_hold_q     <= 80'd0;
      fb_select_q    <= 1'b0;
      swap_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cpu_ack_q      <= (state_d == ST_ACK);
      vga_pend_q     <= bus.vga_rd;
      fb_select_q    <= fb_select_d;
      swap_pending_q <= swap_pending_d;
      if (state_q == ST_RD) begin
        cpu_rdata_q <= bus.mem_rdata;
      end
      if (vga_pend_q) begin
        vga_hold_q <= bus.mem_rdata;
      end
    end
  end

  // The return cycle forwards memory data directly so VGA sees 1-cycle latency.
  assign bus.vga_data     = vga_pend_q ? bus.mem_rdata : vga_hold_q;
  assign bus.cpu_rdata    = cpu_rdata_q;
  assign bus.cpu_ack      = cpu_ack_q;
  assign bus.mem_en       = mem_en_s;
  assign bus.mem_we       = mem_we_s;
  assign bus.mem_addr     = mem_addr_s;
  assign bus.mem_wdata    = bus.cpu_wdata;
  assign bus.fb_select    = fb_select_q;
  assign bus.swap_pending = swap_pending_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: behavioural 1-cycle memory plus an
// event scoreboard checked every cycle on the falling edge.
module tb_fb_arbiter;

  localparam int K_ISS  = 0;
  localparam int K_VGA  = 1;
  localparam int K_ACKR = 2;
  localparam int K_ACKW = 3;
  localparam int K_SEL  = 4;

  typedef struct {
    int          due;
    int          kind;
    logic [79:0] val;
  } ev_t;

  logic        clk;
  logic        rst;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        chk_en = 1'b0;
  ev_t         sb[$];
  logic [79:0] ref_mem [int];
  logic [79:0] exp_vga;
  logic [79:0] exp_rdata;
  logic [1:0]  exp_sel;
  logic        m_sel;
  logic        m_pend;

  logic [16:0] w_addr [0:15];
  logic [79:0] w_data [0:15];
  logic [15:0] w_v;
  logic [79:0] mem_rdata_q;

  fb_arbiter_if #(.ADDR_W(17)) bus ();

  fb_arbiter #(.ADDR_W(17)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [79:0] pat(input logic [16:0] a);
    if (a == 17'h10000) return {10{8'hAA}};
    return {8'hC3, 7'd0, a, 8'h3C, 23'd0, ~a};
  endfunction

  function automatic logic [79:0] mem_lookup(input logic [16:0] a);
    logic [79:0] r;
    r = pat(a);
    for (int i = 0; i < 16; i++) if (w_v[i] && (w_addr[i] == a)) r = w_data[i];
    return r;
  endfunction

  function automatic int wslot(input logic [16:0] a);
    for (int i = 0; i < 16; i++) if (w_v[i] && (w_addr[i] == a)) return i;
    for (int i = 0; i < 16; i++) if (!w_v[i]) return i;
    return 15;
  endfunction

  function automatic logic [79:0] exp_mem(input logic [16:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return pat(a);
  endfunction

  // Behavioural single-port memory: read data valid one cycle after issue, junk otherwise.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      w_v         <= 16'd0;
      mem_rdata_q <= 80'd0;
    end else begin
      if (bus.mem_en && !bus.mem_we) mem_rdata_q <= mem_lookup(bus.mem_addr);
      else                           mem_rdata_q <= {5{16'hDEAD}};
      if (bus.mem_en && bus.mem_we) begin
        w_addr[wslot(bus.mem_addr)] <= bus.mem_addr;
        w_data[wslot(bus.mem_addr)] <= bus.mem_wdata;
        w_v[wslot(bus.mem_addr)]    <= 1'b1;
      end
    end
  end

  assign bus.mem_rdata = mem_rdata_q;

  task automatic check_eq(input string tag, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", tag, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int off, input logic [79:0] val);
    sb.push_back('{due: cyc + off, kind: kind, val: val});
  endtask

  task automatic set_vga(input logic v, input logic [16:0] a);
    bus.vga_rd   = v;
    bus.vga_addr = {23'($urandom), a};
    if (v) begin
      push(K_ISS, 0, {61'd0, 1'b1, 1'b0, a});
      push(K_VGA, 1, exp_mem(a));
    end
  endtask

  // One CPU transaction; vmask[k] drives a VGA read in the k-th cycle of it.
  task automatic cpu_op(input logic we, input logic [16:0] a, input logic [79:0] d,
                        input logic [7:0] vmask, input logic [16:0] va);
    int ph;
    ph = 0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = {23'($urandom), a};
    bus.cpu_wdata = d;
    for (int k = 0; (k < 8) && (ph != 3); k++) begin
      set_vga(vmask[k], va + 17'(k));
      case (ph)
        0: if (!vmask[k]) begin
             push(K_ISS, 0, {61'd0, 1'b1, we, a});
             if (we) begin
               push(K_ACKW, 1, 80'd0);
               ref_mem[int'(a)] = d;
               ph = 2;
             end else begin
               push(K_ACKR, 2, exp_mem(a));
               ph = 1;
             end
           end
        1: ph = 2;
        2: ph = 3;
        default: ph = 3;
      endcase
      tick();
    end
    bus.cpu_req = 1'b0;
    set_vga(1'b0, 17'd0);
  endtask

  task automatic swap_cyc(input logic sr, input logic fe);
    bus.swap_req  = sr;
    bus.frame_end = fe;
    if (fe && (m_pend || sr)) begin
      m_sel  = ~m_sel;
      m_pend = 1'b0;
    end else if (sr) begin
      m_pend = 1'b1;
    end
    push(K_SEL, 1, {78'd0, m_sel, m_pend});
    tick();
    bus.swap_req  = 1'b0;
    bus.frame_end = 1'b0;
  endtask

  // Per-cycle scoreboard: retire due events, then compare every observable output.
  always @(negedge clk) begin
    logic [79:0] e_iss;
    logic        got_iss;
    logic        e_ack;
    if (chk_en) begin
      got_iss = 1'b0;
      e_ack   = 1'b0;
      e_iss   = 80'd0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          case (sb[i].kind)
            K_ISS:   begin got_iss = 1'b1; e_iss = sb[i].val; end
            K_VGA:   exp_vga = sb[i].val;
            K_ACKR:  begin e_ack = 1'b1; exp_rdata = sb[i].val; end
            K_ACKW:  e_ack = 1'b1;
            K_SEL:   exp_sel = sb[i].val[1:0];
            default: ;
          endcase
          sb.delete(i);
        end else if (sb[i].due < cyc) begin
          check_eq("stale_event", 80'(sb[i].due), 80'(cyc));
          sb.delete(i);
        end
      end
      check_eq("mem_en_we", {78'd0, bus.mem_en, bus.mem_we}, {78'd0, e_iss[18:17]});
      if (got_iss) check_eq("mem_addr", 80'(bus.mem_addr), {63'd0, e_iss[16:0]});
      check_eq("mem_wdata", bus.mem_wdata, bus.cpu_wdata);
      check_eq("cpu_ack", 80'(bus.cpu_ack), 80'(e_ack));
      check_eq("cpu_rdata", bus.cpu_rdata, exp_rdata);
      check_eq("vga_data", bus.vga_data, exp_vga);
      check_eq("fb_sel_pend", {78'd0, bus.fb_select, bus.swap_pending}, {78'd0, exp_sel});
    end
  end

  task automatic clear_inputs();
    bus.vga_rd = 1'b0;  bus.vga_addr = 40'd0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 40'd0; bus.cpu_wdata = 80'd0;
    bus.swap_req = 1'b0; bus.frame_end = 1'b0;
  endtask

  task automatic reset_model();
    sb.delete();
    ref_mem.delete();
    exp_vga = 80'd0; exp_rdata = 80'd0; exp_sel = 2'b00;
    m_sel = 1'b0; m_pend = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_mem_en"},    80'(bus.mem_en), 80'd0);
    check_eq({pfx, "_mem_we"},    80'(bus.mem_we), 80'd0);
    check_eq({pfx, "_cpu_ack"},   80'(bus.cpu_ack), 80'd0);
    check_eq({pfx, "_cpu_rdata"}, bus.cpu_rdata, 80'd0);
    check_eq({pfx, "_vga_data"},  bus.vga_data, 80'd0);
    check_eq({pfx, "_fb_select"}, 80'(bus.fb_select), 80'd0);
    check_eq({pfx, "_swap_pend"}, 80'(bus.swap_pending), 80'd0);
  endtask

  initial begin
    reset_model();
    clear_inputs();
    rst = 1'b1;
    bus.vga_rd  = 1'b1;
    bus.cpu_req = 1'b1;
    bus.cpu_we  = 1'b1;
    repeat (2) tick();
    check_reset_outputs("rst");
    clear_inputs();
    rst = 1'b0;
    tick();
    chk_en = 1'b1;

    cpu_op(1'b1, 17'h00105, 80'h1234, 8'h00, 17'd0);
    cpu_op(1'b0, 17'h00105, 80'd0, 8'h00, 17'd0);
    cpu_op(1'b0, 17'h00200, 80'd0, 8'h01, 17'h00300);
    cpu_op(1'b0, 17'h00105, 80'd0, 8'h03, 17'h00310);

    set_vga(1'b1, 17'h10000);
    tick();
    set_vga(1'b0, 17'd0);
    cpu_op(1'b1, 17'h00400, {5{16'h5A5A}}, 8'h00, 17'd0);
    cpu_op(1'b0, 17'h00400, 80'd0, 8'h00, 17'd0);
    tick();

    cpu_op(1'b0, 17'h00105, 80'd0, 8'h06, 17'h00500);
    cpu_op(1'b1, 17'h00600, {5{16'hC0DE}}, 8'h02, 17'h00700);
    cpu_op(1'b0, 17'h00600, 80'd0, 8'h04, 17'h00400);

    for (int n = 0; n < 8; n++) begin
      logic        we;
      logic [16:0] a;
      we = (n < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      a  = 17'($urandom_range(16'h0800, 16'h0810));
      cpu_op(we, a, {$urandom, $urandom, 16'($urandom)}, 8'($urandom_range(0, 7)),
             17'($urandom_range(16'h0800, 16'h0810)));
    end

    swap_cyc(1'b1, 1'b0);
    swap_cyc(1'b1, 1'b0);
    swap_cyc(1'b0, 1'b0);
    swap_cyc(1'b0, 1'b1);
    swap_cyc(1'b0, 1'b1);
    swap_cyc(1'b1, 1'b1);
    swap_cyc(1'b1, 1'b0);
    swap_cyc(1'b1, 1'b1);
    tick();

    set_vga(1'b1, 17'h10000);
    tick();
    set_vga(1'b0, 17'd0);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 40'h00105;
    push(K_ISS, 0, {61'd0, 1'b1, 1'b0, 17'h00105});
    tick();
    chk_en = 1'b0;
    rst = 1'b1;
    bus.vga_rd = 1'b1;
    #2;
    check_reset_outputs("abort");
    for (int n = 0; n < 3; n++) begin
      tick();
      check_eq("abort_ack_low", 80'(bus.cpu_ack), 80'd0);
      check_eq("abort_mem_en", 80'(bus.mem_en), 80'd0);
    end
    reset_model();
    clear_inputs();
    rst = 1'b0;
    tick();
    chk_en = 1'b1;
    repeat (3) tick();
    cpu_op(1'b0, 17'h00105, 80'd0, 8'h00, 17'd0);
    repeat (2) tick();

    chk_en = 1'b0;
    check_eq("sb_empty", 80'(sb.size()), 80'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
